// File: rtl/uart_framed.sv
// uart_framed: UART transmitter and receiver with configurable data, parity and stop bits.
// Define UART_FRAMED_LOOPBACK_EN to add a loopback input that routes the internal tx into RX and holds the tx pin high.
module uart_framed #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef UART_FRAMED_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] C_END = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
  localparam logic [2:0] D_END = 3'(DATA_BITS - 1);
  localparam logic [2:0] S_END = 3'(STOP_BITS - 1);
  localparam logic [7:0] MASK = 8'(2 ** DATA_BITS - 1);
  localparam logic ODD = (PARITY == 1);

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $error("uart_framed: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t r_ts, w_ts;
  logic [CW-1:0] r_tcnt, w_tcnt;
  logic [2:0] r_tbit, w_tbit;
  logic [7:0] r_tsh, w_tsh;
  logic r_tpar, w_tpar, r_tx, w_tx, r_trdy, w_trdy, w_tend;

  assign w_tend = (r_tcnt == C_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts <= IDLE;
      r_tcnt <= '0;
      r_tbit <= '0;
      r_tsh <= '0;
      r_tpar <= 1'b0;
      r_tx <= 1'b1;
      r_trdy <= 1'b0;
    end else begin
      r_ts <= w_ts;
      r_tcnt <= w_tcnt;
      r_tbit <= w_tbit;
      r_tsh <= w_tsh;
      r_tpar <= w_tpar;
      r_tx <= w_tx;
      r_trdy <= w_trdy;
    end
  end

  always_comb begin
    w_ts = r_ts;
    w_tcnt = r_tcnt + 1'b1;
    w_tbit = r_tbit;
    w_tsh = r_tsh;
    w_tpar = r_tpar;
    w_tx = r_tx;
    w_trdy = r_trdy;
    case (r_ts)
      IDLE: begin
        w_tcnt = '0;
        w_tx = 1'b1;
        w_trdy = 1'b1;
        if (r_trdy && tx_valid) begin
          w_ts = START;
          w_tx = 1'b0;
          w_trdy = 1'b0;
          w_tbit = '0;
          w_tsh = tx_data & MASK;
          w_tpar = ^(tx_data & MASK) ^ ODD;
        end
      end
      START: if (w_tend) begin
        w_ts = DATA;
        w_tcnt = '0;
        w_tx = r_tsh[0];
      end
      DATA: if (w_tend) begin
        w_tcnt = '0;
        w_tsh = r_tsh >> 1;
        w_tbit = r_tbit + 1'b1;
        w_tx = r_tsh[1];
        if (r_tbit == D_END) begin
          w_tbit = '0;
          if (PARITY != 0) begin
            w_ts = PAR;
            w_tx = r_tpar;
          end else begin
            w_ts = STOP;
            w_tx = 1'b1;
          end
        end
      end
      PAR: if (w_tend) begin
        w_ts = STOP;
        w_tcnt = '0;
        w_tx = 1'b1;
      end
      STOP: if (w_tend) begin
        w_tcnt = '0;
        w_tbit = r_tbit + 1'b1;
        if (r_tbit == S_END) begin
          w_ts = IDLE;
          w_tbit = '0;
          w_trdy = 1'b1;
        end
      end
      default: w_ts = IDLE;
    endcase
  end

  logic w_rxin, r_s1, r_s2, w_rx;
`ifdef UART_FRAMED_LOOPBACK_EN
  assign w_rxin = loopback ? r_tx : rx;
  assign tx = loopback ? 1'b1 : r_tx;
`else
  assign w_rxin = rx;
  assign tx = r_tx;
`endif
  assign tx_ready = r_trdy;
  assign w_rx = r_s2;

  state_t r_rs, w_rs;
  logic [CW-1:0] r_rcnt, w_rcnt;
  logic [2:0] r_rbit, w_rbit;
  logic [7:0] r_rsh, w_rsh, r_rdata, w_rdata;
  logic r_pe, w_pe, r_fe, w_fe, r_brk, w_brk, w_rend;
  logic r_rvalid, w_rvalid, r_rperr, w_rperr, r_rferr, w_rferr;

  assign w_rend = (r_rcnt == C_END);
  assign rx_data = r_rdata;
  assign rx_valid = r_rvalid;
  assign rx_parity_err = r_rperr;
  assign rx_frame_err = r_rferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_rs <= IDLE;
      r_rcnt <= '0;
      r_rbit <= '0;
      r_rsh <= '0;
      r_pe <= 1'b0;
      r_fe <= 1'b0;
      r_brk <= 1'b0;
      r_rdata <= '0;
      r_rvalid <= 1'b0;
      r_rperr <= 1'b0;
      r_rferr <= 1'b0;
    end else begin
      r_s1 <= w_rxin;
      r_s2 <= r_s1;
      r_rs <= w_rs;
      r_rcnt <= w_rcnt;
      r_rbit <= w_rbit;
      r_rsh <= w_rsh;
      r_pe <= w_pe;
      r_fe <= w_fe;
      r_brk <= w_brk;
      r_rdata <= w_rdata;
      r_rvalid <= w_rvalid;
      r_rperr <= w_rperr;
      r_rferr <= w_rferr;
    end
  end

  // r_brk blocks new starts after a frame error until the line has been seen high
  always_comb begin
    w_rs = r_rs;
    w_rcnt = r_rcnt + 1'b1;
    w_rbit = r_rbit;
    w_rsh = r_rsh;
    w_pe = r_pe;
    w_fe = r_fe;
    w_brk = r_brk & ~w_rx;
    w_rdata = r_rdata;
    w_rvalid = 1'b0;
    w_rperr = r_rperr;
    w_rferr = r_rferr;
    case (r_rs)
      IDLE: begin
        w_rcnt = '0;
        if (!w_rx && !r_brk) begin
          w_rs = START;
          w_rbit = '0;
          w_rsh = '0;
          w_pe = 1'b0;
          w_fe = 1'b0;
        end
      end
      START: if (r_rcnt == C_HALF) begin
        w_rcnt = '0;
        if (w_rx) w_rs = IDLE;
        else w_rs = DATA;
      end
      DATA: if (w_rend) begin
        w_rcnt = '0;
        w_rsh[r_rbit] = w_rx;
        w_rbit = r_rbit + 1'b1;
        if (r_rbit == D_END) begin
          w_rbit = '0;
          if (PARITY != 0) w_rs = PAR;
          else w_rs = STOP;
        end
      end
      PAR: if (w_rend) begin
        w_rcnt = '0;
        w_pe = ^r_rsh ^ w_rx ^ ODD;
        w_rs = STOP;
      end
      STOP: if (w_rend) begin
        w_rcnt = '0;
        w_rbit = r_rbit + 1'b1;
        w_fe = r_fe | ~w_rx;
        if (r_rbit == S_END) begin
          w_rs = IDLE;
          w_rbit = '0;
          w_rvalid = 1'b1;
          w_rdata = r_rsh;
          w_rperr = r_pe;
          w_rferr = r_fe | ~w_rx;
          w_brk = r_fe | ~w_rx;
        end
      end
      default: w_rs = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_framed.sv
// tb_uart_framed: directed checks of uart_framed in 8N1, 7E2 and 8O1 configurations at 10 clocks per bit.
module tb_uart_framed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic drv_a = 1'b1, drv_b = 1'b1, drv_c = 1'b1, ext_lb = 1'b0, lb = 1'b0;
  logic tx_ready_a, tx_a, rx_valid_a, perr_a, ferr_a, w_rx_a;
  logic tx_ready_b, tx_b, rx_valid_b, perr_b, ferr_b;
  logic tx_ready_c, tx_c, rx_valid_c, perr_c, ferr_c;
  logic [7:0] rx_data_a, rx_data_b, rx_data_c;
  int n_a = 0, n_b = 0, n_c = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;
  assign w_rx_a = ext_lb ? tx_a : drv_a;

  uart_framed #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst),
`ifdef UART_FRAMED_LOOPBACK_EN
    .loopback(lb),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_a), .tx(tx_a), .rx(w_rx_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a));

  uart_framed #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst(rst),
`ifdef UART_FRAMED_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready_b), .tx(tx_b), .rx(drv_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b));

  uart_framed #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst),
`ifdef UART_FRAMED_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready_c), .tx(tx_c), .rx(drv_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_parity_err(perr_c), .rx_frame_err(ferr_c));

  always @(negedge clk) begin
    if (rx_valid_a) n_a++;
    if (rx_valid_b) n_b++;
    if (rx_valid_c) n_c++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      case (sel)
        0: drv_a = bits[i];
        1: drv_b = bits[i];
        default: drv_c = bits[i];
      endcase
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    int s, bad, low;
    logic [9:0] fexp, got;
    repeat (2) @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_tx_ready", tx_ready_a, 0);
    check("rst_rx_valid", rx_valid_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_errs", {perr_a, ferr_a}, 0);
    check("rst_7e2", {tx_b, tx_ready_b, rx_data_b}, 10'h200);
    check("rst_8o1", {tx_c, tx_ready_c, perr_c, ferr_c}, 4'b1000);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tx_ready_a, 1);

    send(8'hA5);
    fexp = {1'b1, 8'hA5, 1'b0};
    got = '0;
    bad = 0;
    low = 0;
    for (int k = 0; k < 100; k++) begin
      if (tx_a !== fexp[k / 10]) bad++;
      if (tx_ready_a === 1'b0) low++;
      if (k % 10 == 5) got[k / 10] = tx_a;
      @(negedge clk);
    end
    check("tx_a5_bits", got, 10'b1101001010);
    check("tx_a5_hold", bad, 0);
    check("tx_ready_low", low, 100);
    check("tx_ready_back", {tx_ready_a, tx_a}, 2'b11);

    s = n_b;
    drive(1, {2'b11, 1'b0, 7'h35, 1'b0}, 11);
    drv_b = 1'b1;
    repeat (20) @(negedge clk);
    check("7e2_strobes", n_b - s, 1);
    check("7e2_data", rx_data_b, 8'h35);
    check("7e2_errs", {perr_b, ferr_b}, 0);

    s = n_c;
    drive(2, {1'b1, 1'b0, 8'h00, 1'b0}, 11);
    drv_c = 1'b1;
    repeat (20) @(negedge clk);
    check("8o1_strobes", n_c - s, 1);
    check("8o1_data", rx_data_c, 8'h00);
    check("8o1_perr", perr_c, 1);
    check("8o1_ferr", ferr_c, 0);

    s = n_a;
    drv_a = 1'b0;
    repeat (3) @(negedge clk);
    drv_a = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_strobe", n_a - s, 0);
    drive(0, {1'b1, 8'h3C, 1'b0}, 10);
    repeat (20) @(negedge clk);
    check("3c_strobes", n_a - s, 1);
    check("3c_data", rx_data_a, 8'h3C);
    check("3c_errs", {perr_a, ferr_a}, 0);

    s = n_a;
    drive(0, {1'b0, 8'h55, 1'b0}, 10);
    repeat (30) @(negedge clk);
    check("ferr_strobes", n_a - s, 1);
    check("ferr_flag", ferr_a, 1);
    check("ferr_data", rx_data_a, 8'h55);
    repeat (120) @(negedge clk);
    check("break_no_strobe", n_a - s, 1);
    drv_a = 1'b1;
    repeat (20) @(negedge clk);
    check("break_release", n_a - s, 1);
    drive(0, {1'b1, 8'h81, 1'b0}, 10);
    repeat (20) @(negedge clk);
    check("after_break_strobes", n_a - s, 2);
    check("after_break_data", {rx_data_a, ferr_a}, 9'h102);

    ext_lb = 1'b1;
    s = n_a;
    send(8'h96);
    repeat (120) @(negedge clk);
    check("ext_lb_strobes", n_a - s, 1);
    check("ext_lb_data", rx_data_a, 8'h96);

    s = n_a;
    send(8'h00);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx_a, 1);
    check("midrst_ready", tx_ready_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("midrst_no_strobe", n_a - s, 0);
    check("midrst_idle", {tx_ready_a, tx_a}, 2'b11);
    ext_lb = 1'b0;

`ifdef UART_FRAMED_LOOPBACK_EN
    lb = 1'b1;
    s = n_a;
    bad = 0;
    send(8'hC3);
    for (int k = 0; k < 120; k++) begin
      if (tx_a !== 1'b1) bad++;
      @(negedge clk);
    end
    check("lb_tx_high", bad, 0);
    check("lb_strobes", n_a - s, 1);
    check("lb_data", rx_data_a, 8'hC3);
    send(8'h00);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("lb_rst_tx", tx_a, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("lb_rst_no_strobe", n_a - s, 1);
    lb = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
